// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types, default widths and round-robin search helper
//               for the RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;
  localparam int DEF_BW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_BUSY = 2'd2
  } arb_state_t;

  // First requesting index at or after ptr, wrapping modulo n (n <= 4).
  function automatic logic [1:0] rr_next_idx(input logic [3:0] req,
                                             input logic [1:0] ptr,
                                             input int         n);
    logic [1:0] pick;
    logic       found;
    int         j;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      j = (int'(ptr) + k) % n;
      if (!found && (k < n) && req[j[1:0]]) begin
        pick  = j[1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
// ============================================================================
// Module      : ram_port_arbiter_if
// Description : Requester command/return bundle plus the shared RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_port_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int BW   = 2
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    wr;
  logic [NREQ-1:0]    last;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] data;
  logic [NREQ*BW-1:0] byte_en;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rd_valid;
  logic [DW-1:0]      rd_data;

  logic [AW-1:0]      ram_address;
  logic [DW-1:0]      ram_data;
  logic [BW-1:0]      ram_byte_en;
  logic               ram_wr;
  logic               ram_clock_en;
  logic [DW-1:0]      ram_q;

  modport slave (
    input  req, wr, last, addr, data, byte_en, ram_q,
    output gnt, rd_valid, rd_data,
           ram_address, ram_data, ram_byte_en, ram_wr, ram_clock_en
  );

  modport master (
    output req, wr, last, addr, data, byte_en, ram_q,
    input  gnt, rd_valid, rd_data,
           ram_address, ram_data, ram_byte_en, ram_wr, ram_clock_en
  );

endinterface

`default_nettype wire

// File: rtl/ram_arb_rr_pick.sv
// ============================================================================
// Module      : ram_arb_rr_pick
// Description : Combinational round-robin picker: one-hot winner and index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arb_rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  logic [3:0] req4;
  logic [1:0] ptr2;
  logic [1:0] idx2;
  logic       unused_idx;

  always_comb begin
    req4            = '0;
    req4[NREQ-1:0]  = req;
    ptr2            = '0;
    ptr2[IW-1:0]    = ptr;
  end

  assign idx2       = rr_next_idx(req4, ptr2, NREQ);
  assign idx        = idx2[IW-1:0];
  assign unused_idx = ^idx2;

  // An all-zero request vector yields an all-zero one-hot.
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_onehot
      assign onehot[i] = req[i] && (idx2 == 2'(i));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module      : ram_port_arbiter
// Description : Round-robin burst arbiter sharing one registered RAM port
//               among NREQ requesters, with tagged read-data return.
//               Macro RAM_ARB_BURST_EN enables multi-beat grants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int BW        = DEF_BW,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner, rr_ptr, pick_idx;
  logic [NREQ-1:0] pick_onehot, gnt;
  logic            pick_any, own_req, beat, rel;

  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [BW-1:0]   sel_be;
  logic            sel_wr;

  logic [AW-1:0]   ram_address;
  logic [DW-1:0]   ram_data;
  logic [BW-1:0]   ram_byte_en;
  logic            ram_wr, ram_clock_en;
  logic            tag0_v, tag1_v;
  logic [IW-1:0]   tag0, tag1;
  logic [NREQ-1:0] rd_valid;
  logic [DW-1:0]   rd_data;

`ifdef RAM_ARB_BURST_EN
  logic [7:0]      beat_cnt;
`else
  logic            unused_last;
  assign unused_last = ^bus.last;
`endif

  ram_arb_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (bus.req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign pick_any = |pick_onehot;
  assign own_req  = bus.req[owner];
  assign sel_addr = bus.addr[int'(owner)*AW +: AW];
  assign sel_data = bus.data[int'(owner)*DW +: DW];
  assign sel_be   = bus.byte_en[int'(owner)*BW +: BW];
  assign sel_wr   = bus.wr[owner];

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    beat      = 1'b0;
    rel       = 1'b0;
    case (state)
      ST_IDLE: if (|bus.req) state_nxt = ST_ARB;
      ST_ARB:  state_nxt = pick_any ? ST_BUSY : ST_IDLE;
      ST_BUSY: begin
        gnt[owner] = own_req;
        beat       = own_req;
`ifdef RAM_ARB_BURST_EN
        rel = !own_req || bus.last[owner] || (beat_cnt == 8'(MAX_BURST-1));
`else
        rel = 1'b1;
`endif
        if (rel) state_nxt = ST_ARB;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
`ifdef RAM_ARB_BURST_EN
      beat_cnt <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_ARB && pick_any) begin
        owner <= pick_idx;
`ifdef RAM_ARB_BURST_EN
        beat_cnt <= '0;
`endif
      end
`ifdef RAM_ARB_BURST_EN
      if (beat) beat_cnt <= beat_cnt + 8'd1;
`endif
      if (state == ST_BUSY && rel)
        rr_ptr <= (owner == IW'(NREQ-1)) ? '0 : owner + IW'(1);
    end
  end

  // Two-stage tag pipe lines up with the RAM's registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_address  <= '0;
      ram_data     <= '0;
      ram_byte_en  <= '0;
      ram_wr       <= 1'b0;
      ram_clock_en <= 1'b0;
      tag0_v       <= 1'b0;
      tag1_v       <= 1'b0;
      tag0         <= '0;
      tag1         <= '0;
      rd_valid     <= '0;
      rd_data      <= '0;
    end else begin
      ram_clock_en <= beat;
      ram_wr       <= beat && sel_wr;
      if (beat) begin
        ram_address <= sel_addr;
        ram_data    <= sel_data;
        ram_byte_en <= sel_be;
      end
      tag0_v <= beat && !sel_wr;
      tag0   <= owner;
      tag1_v <= tag0_v;
      tag1   <= tag0;
      for (int i = 0; i < NREQ; i++)
        rd_valid[i] <= tag1_v && (tag1 == IW'(i));
      if (tag1_v) rd_data <= bus.ram_q;
    end
  end

  assign bus.gnt          = gnt;
  assign bus.rd_valid     = rd_valid;
  assign bus.rd_data      = rd_data;
  assign bus.ram_address  = ram_address;
  assign bus.ram_data     = ram_data;
  assign bus.ram_byte_en  = ram_byte_en;
  assign bus.ram_wr       = ram_wr;
  assign bus.ram_clock_en = ram_clock_en;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Directed self-checking bench for ram_port_arbiter with a
//               behavioural one-cycle-latency byte-enabled RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int BW   = 2;

`ifdef RAM_ARB_BURST_EN
  localparam logic [1:0] T3_EXP [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2,
                                         2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
  localparam logic [1:0] T4_EXP [6]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
`else
  localparam logic [1:0] T3_EXP [16] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0,
                                         2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
  localparam logic [1:0] T4_EXP [6]  = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .BW(BW)) bus ();

  ram_port_arbiter #(
    .NREQ      (NREQ),
    .AW        (AW),
    .DW        (DW),
    .BW        (BW),
    .MAX_BURST (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:255];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
      mem[8'h10] <= 16'hBEEF;
      mem[8'h20] <= 16'hFFFF;
      bus.ram_q  <= '0;
    end else if (bus.ram_clock_en) begin
      if (bus.ram_wr) begin
        if (bus.ram_byte_en[0]) mem[bus.ram_address[7:0]][7:0]  <= bus.ram_data[7:0];
        if (bus.ram_byte_en[1]) mem[bus.ram_address[7:0]][15:8] <= bus.ram_data[15:8];
      end else begin
        bus.ram_q <= mem[bus.ram_address[7:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l);
    bus.req  = r;
    bus.wr   = w;
    bus.last = l;
  endtask

  task automatic idle(input int n);
    drive(2'b00, 2'b00, 2'b00);
    repeat (n) go();
  endtask

  task automatic check_zero(input string tag);
    check({tag, " gnt"},          32'(bus.gnt),          32'd0);
    check({tag, " rd_valid"},     32'(bus.rd_valid),     32'd0);
    check({tag, " rd_data"},      32'(bus.rd_data),      32'd0);
    check({tag, " ram_address"},  32'(bus.ram_address),  32'd0);
    check({tag, " ram_data"},     32'(bus.ram_data),     32'd0);
    check({tag, " ram_byte_en"},  32'(bus.ram_byte_en),  32'd0);
    check({tag, " ram_wr"},       32'(bus.ram_wr),       32'd0);
    check({tag, " ram_clock_en"}, 32'(bus.ram_clock_en), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 2'b00);
    bus.addr    = '0;
    bus.data    = '0;
    bus.byte_en = '0;
    repeat (3) go();
    look();
    check_zero("reset");
    rst = 1'b0;
    idle(2);

    // Single read by requester 0
    bus.addr    = {16'h0000, 16'h0010};
    bus.byte_en = 4'b1111;
    go(); drive(2'b01, 2'b00, 2'b01); look();
    check("t1 gnt c0", 32'(bus.gnt), 32'd0);
    go(); look(); check("t1 gnt c1", 32'(bus.gnt), 32'd0);
    go(); look(); check("t1 gnt c2", 32'(bus.gnt), 32'd1);
    go(); drive(2'b00, 2'b00, 2'b00); look();
    check("t1 gnt c3", 32'(bus.gnt), 32'd0);
    check("t1 ram_address c3", 32'(bus.ram_address), 32'h0010);
    check("t1 ram_clock_en c3", 32'(bus.ram_clock_en), 32'd1);
    check("t1 ram_wr c3", 32'(bus.ram_wr), 32'd0);
    go(); look();
    check("t1 ram_clock_en c4", 32'(bus.ram_clock_en), 32'd0);
    check("t1 rd_valid c4", 32'(bus.rd_valid), 32'd0);
    go(); look();
    check("t1 rd_valid c5", 32'(bus.rd_valid), 32'd1);
    check("t1 rd_data c5", 32'(bus.rd_data), 32'hBEEF);
    go(); look(); check("t1 rd_valid c6", 32'(bus.rd_valid), 32'd0);
    idle(3);

    // Byte-enabled write by requester 1, then read back
    bus.addr    = {16'h0020, 16'h0000};
    bus.data    = {16'h12AB, 16'h0000};
    bus.byte_en = {2'b01, 2'b00};
    go(); drive(2'b10, 2'b10, 2'b10); look();
    check("t2 gnt c0", 32'(bus.gnt), 32'd0);
    go(); look(); check("t2 gnt c1", 32'(bus.gnt), 32'd0);
    go(); look(); check("t2 gnt c2", 32'(bus.gnt), 32'd2);
    go(); drive(2'b10, 2'b00, 2'b10); look();
    check("t2 ram_wr c3", 32'(bus.ram_wr), 32'd1);
    check("t2 ram_address c3", 32'(bus.ram_address), 32'h0020);
    check("t2 ram_data c3", 32'(bus.ram_data), 32'h12AB);
    check("t2 ram_byte_en c3", 32'(bus.ram_byte_en), 32'd1);
    check("t2 gnt c3", 32'(bus.gnt), 32'd0);
    go(); look(); check("t2 gnt c4", 32'(bus.gnt), 32'd2);
    go(); drive(2'b00, 2'b00, 2'b00); look();
    check("t2 rd_valid c5", 32'(bus.rd_valid), 32'd0);
    check("t2 ram_clock_en c5", 32'(bus.ram_clock_en), 32'd1);
    check("t2 ram_wr c5", 32'(bus.ram_wr), 32'd0);
    go(); look(); check("t2 rd_valid c6", 32'(bus.rd_valid), 32'd0);
    go(); look();
    check("t2 rd_valid c7", 32'(bus.rd_valid), 32'd2);
    check("t2 rd_data c7", 32'(bus.rd_data), 32'hFFAB);
    idle(3);

    // Contention: both requesters continuous, LastIn never asserted
    bus.addr    = {16'h0041, 16'h0040};
    bus.data    = {16'h1111, 16'h2222};
    bus.byte_en = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      go();
      if (c == 0) drive(2'b11, 2'b11, 2'b00);
      look();
      check($sformatf("t3 gnt c%0d", c), 32'(bus.gnt), 32'(T3_EXP[c]));
    end
    idle(4);

    // LastIn on the second beat of requester 0
    bus.addr = {16'h0000, 16'h0050};
    for (int c = 0; c < 6; c++) begin
      go();
      if (c == 0) drive(2'b01, 2'b01, 2'b00);
      if (c == 3) bus.last = 2'b01;
      look();
      check($sformatf("t4 gnt c%0d", c), 32'(bus.gnt), 32'(T4_EXP[c]));
    end
    idle(4);

    // Reset one cycle after a read grant
    bus.addr = {16'h0000, 16'h0010};
    go(); drive(2'b01, 2'b00, 2'b01);
    go();
    go(); look(); check("t5 gnt c2", 32'(bus.gnt), 32'd1);
    go(); drive(2'b00, 2'b00, 2'b00); rst = 1'b1; look();
    check_zero("t5 mid-reset");
    go(); rst = 1'b0; look();
    check("t5 rd_valid c4", 32'(bus.rd_valid), 32'd0);
    for (int c = 5; c < 9; c++) begin
      go(); look();
      check($sformatf("t5 rd_valid c%0d", c), 32'(bus.rd_valid), 32'd0);
    end

    // After reset: IDLE latency and pointer back at requester 0
    bus.addr = {16'h0061, 16'h0060};
    go(); drive(2'b11, 2'b11, 2'b00); look();
    check("t6 gnt c0", 32'(bus.gnt), 32'd0);
    go(); look(); check("t6 gnt c1", 32'(bus.gnt), 32'd0);
    go(); look(); check("t6 gnt c2", 32'(bus.gnt), 32'd1);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one port of the 16-bit byte-enabled true dual-port packet RAM between up to four requesters, for example the Ethernet RX writer, TX reader and PCIe target. It grants bursts of beats to one owner at a time and drives the RAM port from registers. It returns read data, tagged by a pipelined owner ID, to the requester that issued the read. It sits between the requester blocks and one RAM port (Address/DataIn/ByteEn/Wr/ClockEn/Q).

## Interface
- NREQ, 2: number of requesters, 2..4.
- AW, 16: address width.
- DW, 16: data width.
- BW, 2: byte-enable width, equal to DW/8.
- MAX_BURST, 16: maximum beats per grant, 1..256.

Ports:
- Clock  in  1  single clock for the whole block.
- Reset  in  1  asynchronous, active-high.
- ReqIn  in  NREQ  per-requester request; the command fields below must be valid while it is high.
- WrIn  in  NREQ  1 = write beat, 0 = read beat.
- LastIn  in  NREQ  marks the final beat of a burst.
- AddrIn  in  NREQ*AW  packed addresses; requester i occupies slice [i*AW +: AW].
- DataIn  in  NREQ*DW  packed write data.
- ByteEnIn  in  NREQ*BW  packed byte enables.
- Gnt  out  NREQ  beat accepted this cycle (combinational).
- RdValid  out  NREQ  read data valid for requester i.
- RdData  out  DW  read data, shared by all requesters and qualified by RdValid.
- RamAddress  out  AW  registered address to the RAM port.
- RamDataIn  out  DW  registered write data to the RAM port.
- RamByteEn  out  BW  registered byte enables to the RAM port.
- RamWr  out  1  registered write strobe to the RAM port.
- RamClockEn  out  1  registered clock enable to the RAM port.
- RamQ  in  DW  RAM read port, one-cycle registered output.

## Operation
- State machine states: IDLE, ARB, BUSY.
  - IDLE → ARB when any ReqIn is high.
  - ARB lasts one cycle. It picks the first requesting index at or after RrPtr, modulo NREQ, then registers Owner, clears BeatCnt and enters BUSY. If ReqIn dropped to zero, it returns to IDLE.
  - BUSY: Gnt[Owner] = ReqIn[Owner]. All other Gnt bits are 0.
- Accepted beat (Gnt[i] high):
  - At the next edge, RamAddress, RamDataIn, RamByteEn and RamWr are loaded from requester i, and RamClockEn is set to 1.
  - If the beat is a read, tag i is pushed into a 2-stage tag pipe.
- Cycles with no accepted beat:
  - RamWr = 0 and RamClockEn = 0.
  - The other Ram* outputs hold their values.
- Release: BUSY → ARB happens on an accepted beat that meets any one of these conditions:
  - LastIn[Owner] is high.
  - BeatCnt == MAX_BURST-1.
  - ReqIn[Owner] is low, which releases with no beat.
  - On release, RrPtr = (Owner+1) mod NREQ.
- BeatCnt is 8 bits and increments on each accepted beat. It never wraps within a grant because the release condition fires first.
- Read return: RdValid[tag] = 1 and RdData = RamQ.
- Writes produce no RdValid.
- Reset values:
  - State = IDLE.
  - Owner = 0 and RrPtr = 0.
  - Gnt, RdValid, RamWr and RamClockEn = 0.
  - RamAddress, RamDataIn, RamByteEn and RdData = 0.
  - Tag pipe is cleared.
- Reset mid-burst aborts the grant. Reads still in flight are discarded, so no RdValid is issued for them.

## Timing
- Arbitration: the first Gnt is 2 cycles after ReqIn rises from IDLE.
- Re-arbitration costs 1 bubble cycle (ARB) between grants.
- Within a burst, beats are back-to-back at one per cycle.
- Beat accepted at cycle t:
  - RAM command is presented at t+1.
  - RamQ is valid at t+2.
  - RdValid/RdData are registered at t+3, so read latency is 3 cycles from Gnt.
- A write at t+1 and a read of the same address at t+2 return the new data. The RAM's read-during-write on the same port behaves as read-old, and that case is never exercised here.
- Simultaneous requests in ARB are resolved by the rotating pointer only. No requester can starve; worst-case wait is (NREQ-1)*(MAX_BURST+1) cycles.

## Configuration
- RAM_ARB_BURST_EN
  - Defined: burst grants as described above. LastIn and MAX_BURST are honoured.
  - Undefined: each grant is exactly one beat. LastIn is ignored, BeatCnt is absent, and every accepted beat causes BUSY → ARB with the pointer advanced.

## Structure
- Shared package ram_arb_pkg holds:
  - the state encoding constants ST_IDLE, ST_ARB, ST_BUSY;
  - the default widths (AW, DW, BW);
  - a function for the round-robin next-index search.
- One sub-module: ram_arb_rr_pick. It is combinational and takes the request vector and RrPtr, and produces a one-hot winner plus a winner index. This lets the picker be unit-tested on its own.

## Test plan
- Single read, requester 0: ReqIn=01, Addr=0x0010, preloaded 0xBEEF, LastIn=1 → Gnt[0] at cycle 2, RamAddress=0x0010 at cycle 3, RdValid[0] with RdData=0xBEEF at cycle 5.
- Byte-enabled write then read: requester 1 writes 0x12AB, ByteEn=01, to 0x0020, which holds 0xFFFF → subsequent read returns 0xFFAB.
- Contention: both requesters request 4-beat bursts continuously → grants alternate 0,1,0,1. Each grant is 4 Gnt cycles followed by 1 bubble cycle.
- Burst cap: MAX_BURST=4 and requester 0 never asserts LastIn → release after 4 beats. Requester 1 is granted next.
- Reset mid-read: assert Reset 1 cycle after a read Gnt → all outputs are 0 immediately. No RdValid ever appears for that read, and State=IDLE.
- RAM_ARB_BURST_EN undefined: both requesters request continuously → one beat per grant, strictly alternating, with Gnt every other cycle.
